// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; register 0 is a read-only ID word.
// The write channels are accepted independently and the read channel is fully decoupled from them.
module axi4_lite_slave_regs #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [31:0]              S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,

  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,

  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,

  input  logic [31:0]              S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,

  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,

  output logic [NUM_REGS*32-1:0]   regs_o
);

  localparam int         IDX_W       = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic             aw_held;
  logic [IDX_W-1:0] aw_idx_q;
  logic             aw_oob_q;
  logic             w_held;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;
  logic [31:0]      regs_q [NUM_REGS-1:1];

  // Address decode: byte offset ignored, any bit above the register window flags out-of-range.
  logic [IDX_W-1:0] aw_idx, ar_idx, wr_idx;
  logic             aw_oob, ar_oob, wr_oob;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic             aw_hs, w_hs, ar_hs, commit, wr_ok;

  assign aw_idx = S_AXI_AWADDR[IDX_W+1:2];
  assign aw_oob = |S_AXI_AWADDR[31:IDX_W+2];
  assign ar_idx = S_AXI_ARADDR[IDX_W+1:2];
  assign ar_oob = |S_AXI_ARADDR[31:IDX_W+2];

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = !aw_held && !bvalid_q;
  assign S_AXI_WREADY  = !w_held && !bvalid_q;
  assign S_AXI_ARREADY = !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A write commits as soon as both halves are present, whether held or arriving this edge.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_idx  = aw_held ? aw_idx_q : aw_idx;
  assign wr_oob  = aw_held ? aw_oob_q : aw_oob;
  assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
  assign wr_ok   = !wr_oob && (wr_idx != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      aw_oob_q <= 1'b0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (commit)     aw_held <= 1'b0;
      else if (aw_hs) aw_held <= 1'b1;

      if (commit)    w_held <= 1'b0;
      else if (w_hs) w_held <= 1'b1;

      if (aw_hs) begin
        aw_idx_q <= aw_idx;
        aw_oob_q <= aw_oob;
      end
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // NOTE: the register file is built from flops, not RAM, so it can and must be cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_idx == IDX_W'(i) && wr_strb[b]) regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  logic [31:0] rd_word;
  logic [1:0]  rd_resp;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    if (ar_oob) begin
      rd_resp = RESP_SLVERR;
    end else if (ar_idx == '0) begin
      rd_word = ID_VALUE;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (ar_idx == IDX_W'(i)) rd_word = regs_q[i];
      end
    end
  end

  // Reads sample the register file before any same-edge write commit lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    if (g == 0) begin : g_id
      assign regs_o[31:0] = ID_VALUE;
    end else begin : g_reg
      assign regs_o[32*g +: 32] = regs_q[g];
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Bench for axi4_lite_slave_regs: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_axi4_lite_slave_regs;

  localparam int          N  = 16;
  localparam logic [31:0] ID = 32'hA11E_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   S_AXI_AWADDR;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [31:0]   S_AXI_ARADDR;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic [N*32-1:0] regs_o;

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(.NUM_REGS(N), .ID_VALUE(ID)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .regs_o(regs_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending write halves as queues, responses as flags, memory as an array.
  logic [31:0] m_regs [N];
  logic [31:0] aw_q [$];
  logic [35:0] w_q  [$];
  bit          m_bv, m_rv;
  logic [1:0]  m_br, m_rr;
  logic [31:0] m_rd;
  bit          model_on = 0;

  function automatic void model_read(input logic [31:0] a, output logic [31:0] d,
                                     output logic [1:0] r);
    if (a >= 32'(4 * N)) begin
      d = 32'h0; r = 2'b10;
    end else if ((a >> 2) == 0) begin
      d = ID; r = 2'b00;
    end else begin
      d = m_regs[int'(a >> 2)]; r = 2'b00;
    end
  endfunction

  always @(posedge clk) begin : model_p
    bit          awr, wr, arr;
    logic [31:0] a;
    logic [35:0] wd;
    int          idx;
    if (rst) begin
      for (int i = 0; i < N; i++) m_regs[i] = 32'h0;
      aw_q.delete();
      w_q.delete();
      m_bv = 0; m_br = 2'b00; m_rv = 0; m_rd = 32'h0; m_rr = 2'b00;
    end else begin
      awr = (aw_q.size() == 0) && !m_bv;
      wr  = (w_q.size() == 0) && !m_bv;
      arr = !m_rv;
      if (S_AXI_AWVALID && awr) aw_q.push_back(S_AXI_AWADDR);
      if (S_AXI_WVALID && wr)   w_q.push_back({S_AXI_WSTRB, S_AXI_WDATA});
      if (S_AXI_ARVALID && arr) begin
        model_read(S_AXI_ARADDR, m_rd, m_rr);
        m_rv = 1;
      end else if (m_rv && S_AXI_RREADY) begin
        m_rv = 0;
      end
      if (m_bv && S_AXI_BREADY) m_bv = 0;
      if (aw_q.size() > 0 && w_q.size() > 0) begin
        a  = aw_q.pop_front();
        wd = w_q.pop_front();
        idx = int'(a >> 2);
        if (a < 32'(4 * N) && idx != 0) begin
          for (int b = 0; b < 4; b++)
            if (wd[32 + b]) m_regs[idx][8*b +: 8] = wd[8*b +: 8];
          m_br = 2'b00;
        end else begin
          m_br = 2'b10;
        end
        m_bv = 1;
      end
    end
    model_on = 1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("awready", S_AXI_AWREADY, aw_q.size() == 0 && !m_bv);
      check("wready",  S_AXI_WREADY,  w_q.size() == 0 && !m_bv);
      check("arready", S_AXI_ARREADY, !m_rv);
      check("bvalid",  S_AXI_BVALID,  m_bv);
      check("rvalid",  S_AXI_RVALID,  m_rv);
      if (m_bv) check("bresp", S_AXI_BRESP, m_br);
      if (m_rv) begin
        check("rdata", S_AXI_RDATA, m_rd);
        check("rresp", S_AXI_RRESP, m_rr);
      end
      for (int i = 0; i < N; i++)
        check($sformatf("regs_o[%0d]", i), regs_o[32*i +: 32], (i == 0) ? ID : m_regs[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input string nm);
    bit aw_done, w_done, awh, wh;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
    S_AXI_BREADY = 1;
    while (!(aw_done && w_done) && n < 20) begin
      awh = S_AXI_AWVALID && S_AXI_AWREADY;
      wh  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      n++;
      if (awh) begin aw_done = 1; S_AXI_AWVALID = 0; end
      if (wh)  begin w_done = 1;  S_AXI_WVALID = 0;  end
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    check({nm, "_handshake"}, 32'(aw_done && w_done), 1);
    check({nm, "_bvalid"}, S_AXI_BVALID, 1);
    check({nm, "_bresp"}, S_AXI_BRESP, er);
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                         input string nm);
    bit done, arh;
    int n;
    done = 0; n = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    while (!done && n < 20) begin
      arh = S_AXI_ARREADY;
      tick();
      n++;
      if (arh) begin done = 1; S_AXI_ARVALID = 0; end
    end
    S_AXI_ARVALID = 0;
    check({nm, "_handshake"}, 32'(done), 1);
    check({nm, "_rvalid"}, S_AXI_RVALID, 1);
    check({nm, "_rdata"}, S_AXI_RDATA, ed);
    check({nm, "_rresp"}, S_AXI_RRESP, er);
    S_AXI_RREADY = 1;
    tick();
    S_AXI_RREADY = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    S_AXI_AWADDR = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0;
    S_AXI_ARADDR = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    tick();
    tick();
    rst = 0;
    check("rst_awready", S_AXI_AWREADY, 1);
    check("rst_wready",  S_AXI_WREADY,  1);
    check("rst_arready", S_AXI_ARREADY, 1);
    check("rst_bvalid",  S_AXI_BVALID,  0);
    check("rst_rvalid",  S_AXI_RVALID,  0);
    tick();

    // Simultaneous AW+W, then readback, including an unaligned alias of the same word.
    do_write(32'h04, 32'h1234_5678, 4'hF, 2'b00, "s1_wr");
    do_read(32'h04, 32'h1234_5678, 2'b00, "s1_rd");
    do_read(32'h07, 32'h1234_5678, 2'b00, "s1_rd_unaligned");

    // W three cycles ahead of AW, sparse strobes.
    S_AXI_WDATA = 32'hAABB_CCDD; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
    tick();
    S_AXI_WVALID = 0;
    check("s2_wready_low", S_AXI_WREADY, 0);
    check("s2_no_bvalid", S_AXI_BVALID, 0);
    tick();
    tick();
    S_AXI_AWADDR = 32'h08; S_AXI_AWVALID = 1;
    tick();
    S_AXI_AWVALID = 0;
    check("s2_bvalid", S_AXI_BVALID, 1);
    check("s2_bresp", S_AXI_BRESP, 2'b00);
    check("s2_reg2", regs_o[95:64], 32'h00BB_00DD);
    tick();

    // Writes to the ID word and past the window are rejected; zero strobes write nothing.
    do_write(32'h00, 32'hDEAD_BEEF, 4'hF, 2'b10, "s3_w0");
    do_write(32'h40, 32'hCAFE_F00D, 4'hF, 2'b10, "s3_w40");
    do_write(32'h0C, 32'hFFFF_FFFF, 4'h0, 2'b00, "s3_wstrb0");
    check("s3_reg0", regs_o[31:0], ID);
    check("s3_reg1", regs_o[63:32], 32'h1234_5678);
    check("s3_reg3", regs_o[127:96], 32'h0);
    do_read(32'h00, ID, 2'b00, "s3_rd0");
    do_read(32'h40, 32'h0, 2'b10, "s3_rd40");

    // Back-pressure on B, then on R.
    S_AXI_BREADY = 0;
    S_AXI_AWADDR = 32'h0C; S_AXI_AWVALID = 1;
    S_AXI_WDATA = 32'h1122_3344; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    for (int k = 0; k < 5; k++) begin
      check("s4_bvalid_hold", S_AXI_BVALID, 1);
      check("s4_bresp_hold", S_AXI_BRESP, 2'b00);
      check("s4_awready_low", S_AXI_AWREADY, 0);
      check("s4_wready_low", S_AXI_WREADY, 0);
      tick();
    end
    S_AXI_BREADY = 1;
    tick();
    check("s4_bvalid_clear", S_AXI_BVALID, 0);
    S_AXI_ARADDR = 32'h0C; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    tick();
    S_AXI_ARVALID = 0;
    for (int k = 0; k < 5; k++) begin
      check("s4_rvalid_hold", S_AXI_RVALID, 1);
      check("s4_rdata_hold", S_AXI_RDATA, 32'h1122_3344);
      check("s4_arready_low", S_AXI_ARREADY, 0);
      tick();
    end
    S_AXI_RREADY = 1;
    tick();
    S_AXI_RREADY = 0;
    check("s4_rvalid_clear", S_AXI_RVALID, 0);

    // Read captured on the same edge as a write commit to that register sees the old value.
    S_AXI_AWADDR = 32'h10; S_AXI_AWVALID = 1;
    S_AXI_WDATA = 32'h5566_7788; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    S_AXI_ARADDR = 32'h10; S_AXI_ARVALID = 1;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    check("s5_bvalid", S_AXI_BVALID, 1);
    check("s5_rvalid", S_AXI_RVALID, 1);
    check("s5_rdata_old", S_AXI_RDATA, 32'h0);
    S_AXI_RREADY = 1;
    tick();
    S_AXI_RREADY = 0;
    do_read(32'h10, 32'h5566_7788, 2'b00, "s5_rd_new");

    // Reset with AW held and W outstanding discards the transaction.
    S_AXI_AWADDR = 32'h14; S_AXI_AWVALID = 1;
    tick();
    S_AXI_AWVALID = 0;
    check("s6_aw_held", S_AXI_AWREADY, 0);
    rst = 1;
    tick();
    rst = 0;
    check("s6_bvalid", S_AXI_BVALID, 0);
    check("s6_awready", S_AXI_AWREADY, 1);
    check("s6_wready", S_AXI_WREADY, 1);
    check("s6_arready", S_AXI_ARREADY, 1);
    for (int i = 0; i < N; i++)
      do_read(32'(4 * i), (i == 0) ? ID : 32'h0, 2'b00, $sformatf("s6_rd%0d", i));
    S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    tick();
    S_AXI_WVALID = 0;
    check("s6_no_stale_commit", S_AXI_BVALID, 0);
    S_AXI_AWADDR = 32'h14; S_AXI_AWVALID = 1;
    tick();
    S_AXI_AWVALID = 0;
    check("s6_late_bvalid", S_AXI_BVALID, 1);
    check("s6_reg5", regs_o[191:160], 32'h0BAD_F00D);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
